store_sequencer: RTL and testbench
==================================

# store_sequencer

Sequences stores from the MEM stage onto the data-memory write port through a req/ack handshake. Each accepted store is turned into one or two word-aligned beats with shifted write data and byte enables. The pipeline is stalled while a store is in flight. The block sits between the MEM-stage store request and the data-memory write interface, and owns byte-lane placement for SB/SH/SW.

## Interface
- ADDR_W, 32, address width; fixed at 32 for RV32.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- st_valid  in  1  store request from MEM stage.
- st_ready  out  1  block can accept a store; high only in IDLE.
- st_addr  in  32  byte address.
- st_data  in  32  store data; source bytes start at bit 0.
- st_funct3  in  3  000 SB, 001 SH, 010 SW; all others invalid.
- busy  out  1  pipeline stall; equals !st_ready.
- misaligned  out  1  one-cycle pulse on a rejected misaligned store.
- err  out  1  one-cycle pulse on an invalid funct3.
- mem_req  out  1  write request to data memory.
- mem_addr  out  32  word address; bits [1:0] always 00.
- mem_wdata  out  32  lane-shifted write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- mem_ack  in  1  memory accepted the current beat.

## Operation
- FSM has three states: IDLE, BEAT0, BEAT1. Reset state is IDLE.
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, misaligned=0, err=0, st_ready=1, busy=0.
- A store is accepted when st_valid && st_ready. On accept, with off = st_addr[1:0], the block registers:
  - base_be: SB 0001, SH 0011, SW 1111.
  - be8 = {4'b0, base_be} << off (8 bits).
  - data64 = {32'b0, st_data} << 8*off (64 bits).
  - word0 = {st_addr[31:2], 2'b00}.
  - word1 = word0 + 4, wrapping modulo 2^32.
- Invalid funct3: no memory access; err pulses in the cycle after accept; FSM stays in IDLE.
- Valid funct3: FSM goes to BEAT0 with mem_req=1, mem_addr=word0, mem_wdata=data64[31:0], mem_be=be8[3:0].
- BEAT0 on mem_ack:
  - be8[7:4] != 0: go to BEAT1 with mem_addr=word1, mem_wdata=data64[63:32], mem_be=be8[7:4].
  - otherwise: go to IDLE and drop mem_req.
- BEAT1 on mem_ack: go to IDLE and drop mem_req.
- While mem_req=1 and mem_ack=0, mem_addr, mem_wdata and mem_be hold stable.
- Bytes outside mem_be in mem_wdata are zero.
- A reset asserted mid-operation abandons the store. The memory must tolerate a request withdrawn without ack.

## Timing
- Accept in cycle N: mem_req=1 in cycle N+1.
- mem_ack is sampled in any cycle where mem_req=1. The zero-wait-state case is ack in the same cycle mem_req first rises.
- Single-beat store with immediate ack: accept N, ack N+1, st_ready=1 in N+2. Peak throughput is one store per 2 cycles.
- Two-beat store with immediate acks: accept N, beats in N+1 and N+2, st_ready=1 in N+3.
- Between beats, mem_req stays high with no idle cycle.
- misaligned and err pulse in cycle N+1 only. st_ready stays 1, so a new store can be accepted in N+1.
- mem_ack while mem_req=0 is ignored.

## Configuration
- MISALIGNED_SPLIT_EN defined:
  - All offsets are legal for all three widths.
  - SH at off=1 is a single beat with be 0110.
  - SH at off=3, and SW at off 1–3, are split into two beats.
  - misaligned never asserts.
- MISALIGNED_SPLIT_EN undefined:
  - SH with off[0]=1, or SW with off!=0, is rejected: no memory access, misaligned pulses in N+1.
  - BEAT1 is unreachable and is not built.

## Test plan
- SB, addr 0x1003, data 0xA5, mem_ack tied 1 → one beat: mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5000000; st_ready back 2 cycles after accept.
- SH, addr 0x2002, data 0x1234, ack delayed 3 cycles → mem_be 1100, mem_wdata 0x12340000; outputs stable for all 3 wait cycles; mem_req high 4 cycles total.
- SW, addr 0x3001, data 0xDDCCBBAA, with MISALIGNED_SPLIT_EN → beat0 at 0x3000, be 1110, wdata 0xCCBBAA00; beat1 at 0x3004, be 0001, wdata 0x000000DD. Without the macro → no mem_req, misaligned pulse 1 cycle.
- SW, addr 0xFFFFFFFE, with macro → beat1 mem_addr wraps to 0x00000000, be 0011.
- funct3 011 → err pulse 1 cycle, mem_req stays 0, next store accepted the following cycle.
- reset asserted during BEAT1 wait → mem_req=0, mem_be=0 next cycle; st_ready=1 after reset deasserts.

Source files
------------

// File: rtl/store_sequencer.sv
// store_sequencer: sequences MEM-stage stores (SB/SH/SW) onto the data-memory
// write port as one or two word-aligned beats, with lane-shifted data and
// byte enables. The pipeline is stalled while a store is in flight.
// Optional feature macro: MISALIGNED_SPLIT_EN (split misaligned stores that
// straddle a word boundary into two beats instead of rejecting them).
//
// Handshake: a store is taken on a rising edge where st_valid && st_ready.
// A memory beat is presented while mem_req=1 and retires on a rising edge
// where mem_ack=1; until then mem_addr/mem_wdata/mem_be hold. mem_ack with
// mem_req=0 is ignored.
module store_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_funct3,
    output logic              busy,
    output logic              misaligned,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_err;
    logic              r_misaligned;

    logic [1:0]        w_off;
    logic [3:0]        w_base_be;
    logic              w_f3_ok;
    logic              w_mis;
    logic [31:0]       w_masked;
    logic [3:0]        w_be_lo;
    logic [31:0]       w_wd_lo;
    logic [ADDR_W-1:0] w_word0;

    logic w_load_lo;
    logic w_clear;
    logic w_err_set;
    logic w_mis_set;

`ifdef MISALIGNED_SPLIT_EN
    logic [3:0]        w_be_hi;
    logic [31:0]       w_wd_hi;
    logic [ADDR_W-1:0] w_word1;
    logic [3:0]        r_be_hi;
    logic [31:0]       r_wd_hi;
    logic [ADDR_W-1:0] r_word1;
    logic              w_load_hi;
`endif

    assign w_off   = st_addr[1:0];
    assign w_word0 = {st_addr[ADDR_W-1:2], 2'b00};

    // Decode access width and keep only the source bytes the store writes,
    // so bytes outside the enables reach memory as zero.
    always_comb begin
        w_base_be = 4'b0000;
        w_f3_ok   = 1'b1;
        case (st_funct3)
            3'b000:  w_base_be = 4'b0001;
            3'b001:  w_base_be = 4'b0011;
            3'b010:  w_base_be = 4'b1111;
            default: w_f3_ok   = 1'b0;
        endcase
        w_masked = st_data & {{8{w_base_be[3]}}, {8{w_base_be[2]}},
                              {8{w_base_be[1]}}, {8{w_base_be[0]}}};
    end

`ifdef MISALIGNED_SPLIT_EN
    // Shift enables and data into an 8-byte window; the upper half is beat 1.
    assign {w_be_hi, w_be_lo} = {4'b0000, w_base_be} << w_off;
    assign {w_wd_hi, w_wd_lo} = {32'd0, w_masked} << {w_off, 3'b000};
    assign w_word1            = w_word0 + ADDR_W'(4);
    assign w_mis              = 1'b0;
`else
    // Only naturally aligned accesses are legal, so nothing spills past lane 3.
    assign w_be_lo = w_base_be << w_off;
    assign w_wd_lo = w_masked << {w_off, 3'b000};
    assign w_mis   = ((st_funct3 == 3'b001) && w_off[0]) ||
                     ((st_funct3 == 3'b010) && (w_off != 2'b00));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and datapath load strobes.
    always_comb begin
        w_next    = r_state;
        w_load_lo = 1'b0;
        w_clear   = 1'b0;
        w_err_set = 1'b0;
        w_mis_set = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        w_load_hi = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (st_valid) begin
                    if (!w_f3_ok) begin
                        w_err_set = 1'b1;
                    end else if (w_mis) begin
                        w_mis_set = 1'b1;
                    end else begin
                        w_next    = BEAT0;
                        w_load_lo = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (r_be_hi != 4'b0000) begin
                        w_next    = BEAT1;
                        w_load_hi = 1'b1;
                    end else begin
                        w_next  = IDLE;
                        w_clear = 1'b1;
                    end
`else
                    w_next  = IDLE;
                    w_clear = 1'b1;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (mem_ack) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
`endif
            default: begin
                w_next  = IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    // Beat registers, pending second beat and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_err        <= 1'b0;
            r_misaligned <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            r_be_hi      <= '0;
            r_wd_hi      <= '0;
            r_word1      <= '0;
`endif
        end else begin
            r_err        <= w_err_set;
            r_misaligned <= w_mis_set;
            if (w_load_lo) begin
                r_mem_addr  <= w_word0;
                r_mem_wdata <= w_wd_lo;
                r_mem_be    <= w_be_lo;
`ifdef MISALIGNED_SPLIT_EN
                r_be_hi     <= w_be_hi;
                r_wd_hi     <= w_wd_hi;
                r_word1     <= w_word1;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            if (w_load_hi) begin
                r_mem_addr  <= r_word1;
                r_mem_wdata <= r_wd_hi;
                r_mem_be    <= r_be_hi;
            end
`endif
            if (w_clear) begin
                r_mem_wdata <= '0;
                r_mem_be    <= '0;
            end
        end
    end

    assign st_ready   = (r_state == IDLE);
    assign busy       = ~st_ready;
    assign mem_req    = (r_state != IDLE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign err        = r_err;
    assign misaligned = r_misaligned;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: directed test-plan steps then random stores,
// checked against a byte-by-byte reference model.
module tb_store_sequencer;

    localparam int W = 68;  // {addr[31:0], be[3:0], wdata[31:0]}

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        busy;
    logic        misaligned;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    store_sequencer #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_funct3  (st_funct3),
        .busy       (busy),
        .misaligned (misaligned),
        .err        (err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .dbg_state  (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: walk the store byte by byte; each byte lands in the
    // word holding its address at lane addr%4. Consecutive bytes in the same
    // word share a beat. kind: 0 ok, 1 bad funct3, 2 misaligned.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f3, output int kind, output int n);
        int nbytes;
        logic [31:0] wa [2];
        logic [3:0]  wb [2];
        logic [31:0] wd [2];
        logic [31:0] ba;
        logic [31:0] w;
        int lane;
        kind = 0;
        n    = 0;
        case (f3)
            3'b000:  nbytes = 1;
            3'b001:  nbytes = 2;
            3'b010:  nbytes = 4;
            default: nbytes = 0;
        endcase
        if (nbytes == 0) begin
            kind = 1;
        end else if (!SPLIT && ((a % nbytes) != 0)) begin
            kind = 2;
        end else begin
            for (int j = 0; j < 2; j++) begin
                wa[j] = '0; wb[j] = '0; wd[j] = '0;
            end
            for (int k = 0; k < nbytes; k++) begin
                ba   = a + k;
                w    = ba & 32'hFFFF_FFFC;
                lane = int'(ba % 4);
                if (n == 0 || w != wa[n-1]) begin
                    n++;
                    wa[n-1] = w;
                end
                wb[n-1][lane]        = 1'b1;
                wd[n-1][8*lane +: 8] = d[8*k +: 8];
            end
            for (int j = 0; j < n; j++) exp_q.push_back({wa[j], wb[j], wd[j]});
        end
    endtask

    // Driver: offer one store, then play the memory with 'dly' wait cycles per beat.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input int dly);
        int kind;
        int n;
        int guard;
        logic [W-1:0] e;
        model_push(a, d, f3, kind, n);
        guard = 0;
        while (st_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_accept", st_ready, 1);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f3;
        mem_ack   = 1'($urandom_range(0, 1));  // ignored: no request outstanding
        tick();
        st_valid  = 1'b0;
        mem_ack   = 1'b0;
        st_addr   = $urandom();
        st_data   = $urandom();
        st_funct3 = 3'($urandom_range(0, 7));
        check("err_pulse", err, (kind == 1));
        check("misaligned_pulse", misaligned, (kind == 2));
        if (kind != 0) begin
            check("rejected_no_req", mem_req, 0);
            check("rejected_ready", st_ready, 1);
            return;
        end
        for (int b = 0; b < n; b++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            for (int w = 0; w <= dly; w++) begin
                check("beat_req", mem_req, 1);
                check("beat_busy", busy, 1);
                check("beat_ready", st_ready, 0);
                check("beat_addr", mem_addr, e[67:36]);
                check("beat_be", mem_be, e[35:32]);
                check("beat_wdata", mem_wdata, e[31:0]);
                if (w > 0 || b > 0) begin
                    check("beat_no_err", err, 0);
                    check("beat_no_mis", misaligned, 0);
                end
                mem_ack = (w == dly);
                tick();
                mem_ack = 1'b0;
            end
        end
        check("done_req", mem_req, 0);
        check("done_ready", st_ready, 1);
        check("done_busy", busy, 0);
    endtask

    // Reset in the middle of a store: withdraws the request, clears the beat.
    task automatic reset_mid();
        st_valid  = 1'b1;
        st_addr   = 32'h0000_4001;
        st_data   = 32'h1122_3344;
`ifdef MISALIGNED_SPLIT_EN
        st_funct3 = 3'b010;
`else
        st_funct3 = 3'b001;
        st_addr   = 32'h0000_4000;
`endif
        tick();
        st_valid = 1'b0;
        check("rst_mid_req0", mem_req, 1);
`ifdef MISALIGNED_SPLIT_EN
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rst_mid_beat1_addr", mem_addr, 32'h0000_4004);
`endif
        tick();  // wait cycle with no ack
        check("rst_mid_waiting", mem_req, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_be", mem_be, 0);
        reset = 1'b0;
        tick();
        check("rst_mid_ready", st_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_idle_req", mem_req, 0);
    endtask

    initial begin
        int dly;
        logic [2:0] f3;
        reset     = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_funct3 = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", mem_be, 0);
        check("rst_mis", misaligned, 0);
        check("rst_err", err, 0);
        check("rst_ready", st_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Test-plan steps.
        do_store(32'h0000_1003, 32'h0000_00A5, 3'b000, 0);
        do_store(32'h0000_2002, 32'h0000_1234, 3'b001, 3);
        do_store(32'h0000_3001, 32'hDDCC_BBAA, 3'b010, 0);
        do_store(32'hFFFF_FFFE, 32'h8765_4321, 3'b010, 1);
        do_store(32'h0000_5000, 32'h0BAD_F00D, 3'b011, 0);
        do_store(32'h0000_5004, 32'hCAFE_BABE, 3'b010, 0);  // taken right after err
        do_store(32'h0000_6001, 32'h0000_BEEF, 3'b001, 2);
        do_store(32'h0000_6003, 32'h0000_BEEF, 3'b001, 0);
        reset_mid();

        // Random stores.
        for (int i = 0; i < 80; i++) begin
            f3  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            dly = $urandom_range(0, 3);
            do_store($urandom(), $urandom(), f3, dly);
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
